div_restoring_4bit_ctrl: RTL and testbench

Sequential 4-bit unsigned restoring divider built around one shared 4-bit ripple-carry adder/subtractor. A start/busy/done handshake sequences one subtract-and-restore iteration per clock. The block sits above the adder/subtractor and owns its a/b/c_in/M controls. It is the first multi-cycle arithmetic unit in the combinational-logic series.

---
 rtl/div_restoring_4bit_ctrl_pkg.sv | 24 ++
 rtl/div_restoring_4bit_ctrl_if.sv | 30 +++
 rtl/div_restoring_4bit_ctrl_addsub.sv | 34 +++
 rtl/div_restoring_4bit_ctrl.sv | 110 +++++++++++
 tb/tb_div_restoring_4bit_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/div_restoring_4bit_ctrl_pkg.sv
// ============================================================================
// div_restoring_4bit_ctrl_pkg : shared state encoding and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package div_restoring_4bit_ctrl_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int         ITER         = 4;
   localparam logic [3:0] DBZ_QUOTIENT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_RUN  = RUN,
      ST_DONE = DONE
   } state_t;

endpackage

`default_nettype wire

// File: rtl/div_restoring_4bit_ctrl_if.sv
// ============================================================================
// div_restoring_4bit_ctrl_if : start/busy/done handshake and operand/result bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface div_restoring_4bit_ctrl_if;

   logic       start;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       dbz;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, dbz
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, dbz
   );

endinterface

`default_nettype wire

// File: rtl/div_restoring_4bit_ctrl_addsub.sv
// ============================================================================
// ripple_carry_add_and_sub_4bit_m1 : 4-bit ripple adder/subtractor (M=1 inverts b)
// Rev 1.0
// ============================================================================
`default_nettype none

module ripple_carry_add_and_sub_4bit_m1 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   input  logic       M,
   output logic [3:0] sum,
   output logic       c_out
);

   logic [4:0] w_carry;
   logic [3:0] w_b_eff;

   assign w_carry[0] = c_in;
   assign w_b_eff    = b ^ {4{M}};

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_bit
         assign sum[i]       = a[i] ^ w_b_eff[i] ^ w_carry[i];
         assign w_carry[i+1] = (a[i] & w_b_eff[i]) | (w_carry[i] & (a[i] ^ w_b_eff[i]));
      end
   endgenerate

   assign c_out = w_carry[4];

endmodule

`default_nettype wire

// File: rtl/div_restoring_4bit_ctrl.sv
// ============================================================================
// div_restoring_4bit_ctrl : sequential 4-bit unsigned restoring divider
// Rev 1.0
// ============================================================================
`default_nettype none

module div_restoring_4bit_ctrl
   import div_restoring_4bit_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   div_restoring_4bit_ctrl_if.slave    bus
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ITER - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       r_q, q_q, d_q;
   logic [3:0]       r_d, q_d;
   logic             busy_q, done_q, dbz_q;
   logic [3:0]       quotient_q, remainder_q;

   logic [3:0]       w_shifted;
   logic [3:0]       w_sum;
   logic             w_c_out;

   // R never exceeds 7 before the shift, so the shifted value fits in 4 bits
   assign w_shifted = {r_q[2:0], q_q[3]};

   ripple_carry_add_and_sub_4bit_m1 u_addsub (
      .a     (w_shifted),
      .b     (d_q),
      .c_in  (1'b1),
      .M     (1'b1),
      .sum   (w_sum),
      .c_out (w_c_out)
   );

   // c_out=1 means no borrow: keep the difference and set the quotient bit
   assign r_d = w_c_out ? w_sum : w_shifted;
   assign q_d = {q_q[2:0], w_c_out};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  d_q   <= bus.divisor;
                  q_q   <= bus.dividend;
                  r_q   <= '0;
                  cnt_q <= '0;
                  if (bus.divisor == 4'd0) begin
                     state_q     <= ST_DONE;
                     quotient_q  <= DBZ_QUOTIENT;
                     remainder_q <= bus.dividend;
                     dbz_q       <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                     dbz_q   <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_q     <= ST_DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  quotient_q  <= q_d;
                  remainder_q <= r_d;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               // divide-by-zero results were loaded on entry; their done comes one edge later
               done_q  <= dbz_q;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.dbz       = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_div_restoring_4bit_ctrl.sv
// ============================================================================
// tb_div_restoring_4bit_ctrl : directed + exhaustive check against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_restoring_4bit_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   passed = 0;
   int   total  = 0;
   logic [7:0] exp_q[$];

   div_restoring_4bit_ctrl_if bus ();

   div_restoring_4bit_ctrl #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // returns {dbz, quotient, remainder}
   function automatic logic [8:0] model(input logic [3:0] dvd, input logic [3:0] dvs);
      if (dvs == 4'd0) return {1'b1, 4'hF, dvd};
      return {1'b0, 4'(dvd / dvs), 4'(dvd % dvs)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   always @(negedge clk) begin
      if (!reset && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            logic [7:0] ops;
            logic [8:0] m;
            ops = exp_q.pop_front();
            m   = model(ops[7:4], ops[3:0]);
            chk("model_result", {bus.dbz, bus.quotient, bus.remainder}, m);
         end
      end
      if (!reset) chk("busy_done_exclusive", bus.busy & bus.done, 0);
   end

   task automatic run_op(input logic [3:0] dvd, input logic [3:0] dvs,
                         input logic [3:0] eq, input logic [3:0] er, input logic ed,
                         input string name);
      int  busy_cnt = 0;
      int  lat = -1;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
      exp_q.push_back({dvd, dvs});
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            lat = n;
            chk({name, "_q"},   bus.quotient,  eq);
            chk({name, "_r"},   bus.remainder, er);
            chk({name, "_dbz"}, bus.dbz,       ed);
            break;
         end
      end
      chk({name, "_latency"}, lat, ed ? 1 : 4);
      chk({name, "_busy_cycles"}, busy_cnt, ed ? 0 : 4);
      @(negedge clk);
      chk({name, "_done_pulse"}, bus.done, 0);
      chk({name, "_hold"}, {bus.quotient, bus.remainder}, {eq, er});
   endtask

   initial begin
      int dcnt;
      int idx[3];
      logic [3:0] cq, cr;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      reset = 1'b1;
      #1;
      chk("reset_outputs", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz}, 0);

      chk("model_13_3", model(4'd13, 4'd3), {1'b0, 4'd4, 4'd1});
      chk("model_7_0",  model(4'd7,  4'd0), {1'b1, 4'hF, 4'd7});
      chk("model_15_2", model(4'd15, 4'd2), {1'b0, 4'd7, 4'd1});

      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, "d13_3");
      run_op(4'd15, 4'd2, 4'd7, 4'd1, 1'b0, "d15_2");
      run_op(4'd9,  4'd9, 4'd1, 4'd0, 1'b0, "d9_9");
      run_op(4'd3,  4'd7, 4'd0, 4'd3, 1'b0, "d3_7");
      run_op(4'd0,  4'd5, 4'd0, 4'd0, 1'b0, "d0_5");
      run_op(4'd7,  4'd0, 4'hF, 4'd7, 1'b1, "dbz7_0");
      run_op(4'd8,  4'd2, 4'd4, 4'd0, 1'b0, "d8_2");

      // start re-pulsed and operands changed during RUN of 14/3
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
      exp_q.push_back({4'd14, 4'd3});
      @(posedge clk); #1;
      bus.start = 1'b0;
      dcnt = 0; cq = '0; cr = '0;
      for (int n = 0; n < 14; n++) begin
         @(negedge clk);
         if (n == 1) begin bus.start = 1'b1; bus.dividend = 4'd5; bus.divisor = 4'd1; end
         if (n == 2) begin bus.start = 1'b0; bus.dividend = 4'd2; bus.divisor = 4'd7; end
         if (bus.done) begin dcnt++; cq = bus.quotient; cr = bus.remainder; end
      end
      chk("ignore_start_done_count", dcnt, 1);
      chk("ignore_start_result", {cq, cr}, {4'd4, 4'd2});

      // reset at iteration 2 of 11/2
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 4'd11; bus.divisor = 4'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_outputs", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz}, 0);
      @(negedge clk);
      reset = 1'b0;
      dcnt = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (bus.done) dcnt++;
         if (bus.busy) dcnt++;
      end
      chk("abort_no_done_no_busy", dcnt, 0);
      run_op(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, "d11_2");

      // start held high with 12/5
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
      repeat (3) exp_q.push_back({4'd12, 4'd5});
      dcnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.done) begin
            idx[dcnt] = n;
            chk("held_result", {bus.quotient, bus.remainder}, {4'd2, 4'd2});
            dcnt++;
            if (dcnt == 3) begin bus.start = 1'b0; break; end
         end
      end
      bus.start = 1'b0;
      chk("held_done_count", dcnt, 3);
      if (dcnt == 3) begin
         chk("held_first_latency", idx[0], 4);
         chk("held_period_1", idx[1] - idx[0], 6);
         chk("held_period_2", idx[2] - idx[1], 6);
      end

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            logic [8:0] m;
            m = model(4'(a), 4'(b));
            run_op(4'(a), 4'(b), m[7:4], m[3:0], m[8], "sweep");
         end
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
